// File: rtl/id_operand_forwarder.sv
// Decode-stage operand resolver: prioritised forwarding, load-use stall, and a
// bubble sequencer that isolates serialising instructions (syscall, LL/SC).
module id_operand_forwarder #(
  parameter int DATA_W        = 32,
  parameter int NUM_OPS       = 2,
  parameter int NUM_SRC       = 3,
  parameter int BUBBLE_CYCLES = 4,
  parameter int SEL_W         = $clog2(NUM_SRC + 1)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        in_valid,
  input  logic [NUM_OPS*5-1:0]        in_reg,
  input  logic [NUM_OPS-1:0]          in_use,
  input  logic [NUM_OPS*DATA_W-1:0]   in_raw,
  input  logic [NUM_SRC*5-1:0]        fwd_reg,
  input  logic [NUM_SRC*DATA_W-1:0]   fwd_val,
  input  logic [NUM_SRC-1:0]          fwd_wr,
  input  logic [NUM_SRC-1:0]          fwd_load,
  input  logic                        serialize,
  input  logic                        notify,
  output logic                        out_valid,
  output logic [NUM_OPS*DATA_W-1:0]   out_op,
  output logic [NUM_OPS*SEL_W-1:0]    out_sel,
  output logic                        stall,
  output logic                        sys_pulse,
  output logic                        want_freeze
);

  logic [NUM_OPS*DATA_W-1:0] opVal;
  logic [NUM_OPS*SEL_W-1:0]  opSel;
  logic [NUM_OPS-1:0]        found;
  logic                      hazard;

  logic [2:0]                cnt_q, cnt_d;
  logic                      inhibit_q, inhibit_d;
  logic                      pulse_q, pulse_d;
  logic                      valid_q, issue;
  logic [NUM_OPS*DATA_W-1:0] op_q;
  logic [NUM_OPS*SEL_W-1:0]  sel_q;

  // Lowest-index matching source wins; register 0 always reads the regfile.
  always_comb begin
    opVal  = in_raw;
    opSel  = '0;
    found  = '0;
    hazard = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!found[i] && in_use[i] && fwd_wr[k] && (in_reg[i*5 +: 5] != 5'd0) &&
            (fwd_reg[k*5 +: 5] == in_reg[i*5 +: 5])) begin
          found[i]                     = 1'b1;
          opVal[i*DATA_W +: DATA_W]    = fwd_val[k*DATA_W +: DATA_W];
          opSel[i*SEL_W +: SEL_W]      = SEL_W'(k + 1);
          hazard                       = hazard | fwd_load[k];
        end
      end
    end
  end

  assign stall       = in_valid && hazard;
  assign want_freeze = (serialize || (cnt_q > 3'd2)) && !inhibit_q;

  // Sequencer frozen on stall cycles; the serialising instruction issues at count 2.
  always_comb begin
    cnt_d     = cnt_q;
    inhibit_d = inhibit_q;
    pulse_d   = 1'b0;
    issue     = 1'b0;
    if (!stall) begin
      case (cnt_q)
        3'd0: begin
          inhibit_d = 1'b0;
          if (in_valid && serialize) begin
            cnt_d = 3'(BUBBLE_CYCLES);
          end else begin
            issue = in_valid;
          end
        end
        3'd2: begin
          cnt_d     = 3'd1;
          issue     = in_valid;
          pulse_d   = notify;
          inhibit_d = 1'b1;
        end
        3'd1: begin
          cnt_d     = 3'd0;
          inhibit_d = 1'b0;
        end
        default: cnt_d = cnt_q - 3'd1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q     <= 3'd0;
      inhibit_q <= 1'b0;
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
      op_q      <= '0;
      sel_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      inhibit_q <= inhibit_d;
      pulse_q   <= pulse_d;
      valid_q   <= issue;
      if (issue) begin
        op_q  <= opVal;
        sel_q <= opSel;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_op    = op_q;
  assign out_sel   = sel_q;
  assign sys_pulse = pulse_q;

endmodule
